// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Instruction-memory writer fed by a framed byte stream (UART / debug port).
//   Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes MSB first, CSUM
//   (XOR of every preceding byte). Words are written to BASE_ADDR + 4*k and the
//   CPU is held in reset until a complete frame with a good checksum has landed.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   byte_valid/byte_data    input byte stream; a byte is taken when byte_ready is 1
//   byte_ready              1 while still receiving a frame (not in DONE/ERR)
//   mem_we/addr/wdata       one-cycle write strobe per assembled word
//   cpu_reset               1 until the frame is loaded and verified
//   done / error            sticky status, cleared only by reset
//   words_loaded            count of words written so far
module imem_boot_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   // One extra bit so a MAX_WORDS of 65535 or more never truncates.
   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] len;
   logic [7:0]  csum;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;   // first three bytes of the word being assembled

   logic        accept;
   logic [15:0] len_full;
   logic [7:0]  csum_nxt;
   logic        last_byte;
   logic        last_word;

   always_comb begin
      state_nxt  = state;
      byte_ready = (state != S_DONE) && (state != S_ERR);
      accept     = byte_valid && byte_ready;
      len_full   = {len[15:8], byte_data};
      csum_nxt   = csum ^ byte_data;
      last_byte  = (byte_cnt == 2'd3);
      // words_loaded is the index of the word currently being assembled.
      last_word  = ((words_loaded + 16'd1) == len);

      case (state)
         S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (accept) begin
               if (len_full == 16'd0)              state_nxt = S_CSUM;
               else if ({1'b0, len_full} > MAX_W)  state_nxt = S_ERR;
               else                                state_nxt = S_DATA;
            end
         end
         S_DATA:   if (accept && last_byte && last_word) state_nxt = S_CSUM;
         S_CSUM: begin
            if (accept) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
         end
         default: state_nxt = state;   // DONE and ERR leave only through reset
      endcase
   end

   assign cpu_reset = (state != S_DONE);
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERR);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_LEN_HI;
         len          <= '0;
         csum         <= '0;
         byte_cnt     <= '0;
         word_buf     <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= BASE_ADDR;
         mem_wdata    <= '0;
         words_loaded <= '0;
      end else begin
         state  <= state_nxt;
         mem_we <= 1'b0;
         if (accept) begin
            case (state)
               S_LEN_HI: begin
                  len[15:8] <= byte_data;
                  csum      <= byte_data;
               end
               S_LEN_LO: begin
                  len[7:0] <= byte_data;
                  csum     <= csum_nxt;
               end
               S_DATA: begin
                  csum     <= csum_nxt;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (last_byte) begin
                     // Write is issued the cycle after the 4th byte; the
                     // stream keeps flowing, so no stall is needed.
                     mem_we       <= 1'b1;
                     mem_addr     <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                     mem_wdata    <= {word_buf, byte_data};
                     words_loaded <= words_loaded + 16'd1;
                  end else begin
                     word_buf <= {word_buf[15:0], byte_data};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;

   logic        byte_ready0, mem_we0, cpu_reset0, done0, error0;
   logic [31:0] mem_addr0, mem_wdata0;
   logic [15:0] words_loaded0;
   logic        byte_ready1, mem_we1, cpu_reset1, done1, error1;
   logic [31:0] mem_addr1, mem_wdata1;
   logic [15:0] words_loaded1;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];

   always #5 clk = ~clk;

   imem_boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
      .clock(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
      .mem_wdata(mem_wdata0), .cpu_reset(cpu_reset0), .done(done0),
      .error(error0), .words_loaded(words_loaded0));

   imem_boot_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) dut1 (
      .clock(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
      .byte_ready(byte_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .cpu_reset(cpu_reset1), .done(done1),
      .error(error1), .words_loaded(words_loaded1));

   // Write log, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we0) begin wa0.push_back(mem_addr0); wd0.push_back(mem_wdata0); end
      if (mem_we1) begin wa1.push_back(mem_addr1); wd1.push_back(mem_wdata1); end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(b);
   endtask

   task automatic clear_log();
      wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
   endtask

   task automatic do_reset(input string t);
      @(negedge clk);
      reset      = 1'b1;
      byte_valid = 1'b0;
      @(posedge clk);
      #1;
      chk({t, " rst byte_ready"}, byte_ready0, 1);
      chk({t, " rst mem_we"}, mem_we0, 0);
      chk({t, " rst mem_addr0"}, mem_addr0, 32'h0);
      chk({t, " rst mem_addr1"}, mem_addr1, 32'h100);
      chk({t, " rst mem_wdata"}, mem_wdata0, 0);
      chk({t, " rst cpu_reset"}, cpu_reset0, 1);
      chk({t, " rst done/error"}, {done0, error0}, 0);
      chk({t, " rst words_loaded"}, words_loaded0, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Single-word frame 00 01 20 08 00 05 2C with cycle-exact write checks.
   task automatic frame1(input string t);
      send(8'h00); send(8'h01); send(8'h20); send(8'h08); send(8'h00);
      chk({t, " no early we"}, mem_we0, 0);
      send(8'h05);
      chk({t, " we"}, mem_we0, 1);
      chk({t, " addr"}, mem_addr0, 32'h0);
      chk({t, " wdata"}, mem_wdata0, 32'h2008_0005);
      chk({t, " words_loaded@we"}, words_loaded0, 1);
      chk({t, " cpu_reset in csum"}, cpu_reset0, 1);
      send(8'h2C);
      chk({t, " we dropped"}, mem_we0, 0);
      chk({t, " done"}, done0, 1);
      chk({t, " cpu_reset"}, cpu_reset0, 0);
      chk({t, " error"}, error0, 0);
      chk({t, " byte_ready"}, byte_ready0, 0);
      chk({t, " words_loaded"}, words_loaded0, 1);
      chk({t, " n writes"}, wa0.size(), 1);
      if (wa0.size() == 1) begin
         chk({t, " log addr"}, wa0[0], 32'h0);
         chk({t, " log data"}, wd0[0], 32'h2008_0005);
      end
   endtask

   logic [7:0] f5[10] = '{8'h00, 8'h02, 8'h8C, 8'h09, 8'h00, 8'h00,
                          8'hAC, 8'h09, 8'h00, 8'h04};

   initial begin
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;

      // Test 1: one-word frame
      do_reset("t1");
      clear_log();
      frame1("t1");

      // Test 2: empty frame
      do_reset("t2");
      clear_log();
      send(8'h00); send(8'h00); send(8'h00);
      chk("t2 done", done0, 1);
      chk("t2 cpu_reset", cpu_reset0, 0);
      chk("t2 words_loaded", words_loaded0, 0);
      chk("t2 n writes", wa0.size(), 0);

      // Test 3: bad checksum; write still lands, later bytes ignored
      do_reset("t3");
      clear_log();
      send(8'h00); send(8'h01); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
      send(8'hFF);
      chk("t3 error", error0, 1);
      chk("t3 done", done0, 0);
      chk("t3 cpu_reset", cpu_reset0, 1);
      chk("t3 byte_ready", byte_ready0, 0);
      chk("t3 n writes", wa0.size(), 1);
      send(8'h00); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      repeat (2) @(negedge clk);
      chk("t3 sticky error", error0, 1);
      chk("t3 words frozen", words_loaded0, 1);
      chk("t3 no more writes", wa0.size(), 1);

      // Boundary: N == MAX_WORDS is accepted
      do_reset("tmax");
      send(8'h01); send(8'h00);
      chk("tmax no error", error0, 0);
      chk("tmax byte_ready", byte_ready0, 1);

      // Test 4: N = 257 rejected
      do_reset("t4");
      clear_log();
      send(8'h01);
      chk("t4 no error yet", error0, 0);
      send(8'h01);
      chk("t4 error", error0, 1);
      chk("t4 byte_ready", byte_ready0, 0);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
      repeat (2) @(negedge clk);
      chk("t4 n writes", wa0.size(), 0);
      chk("t4 words_loaded", words_loaded0, 0);

      // Test 5: two words, random gaps, both base addresses
      do_reset("t5");
      clear_log();
      for (int i = 0; i < 10; i++) send_gap(f5[i]);
      send_gap(8'h26);
      chk("t5 done", done1, 1);
      chk("t5 words_loaded", words_loaded1, 2);
      chk("t5 n writes1", wa1.size(), 2);
      chk("t5 n writes0", wa0.size(), 2);
      if (wa1.size() == 2 && wa0.size() == 2) begin
         chk("t5 addr1[0]", wa1[0], 32'h100);
         chk("t5 data1[0]", wd1[0], 32'h8C09_0000);
         chk("t5 addr1[1]", wa1[1], 32'h104);
         chk("t5 data1[1]", wd1[1], 32'hAC09_0004);
         chk("t5 addr0[1]", wa0[1], 32'h4);
      end

      // Test 6: aborted frames leave no write, then a clean retransmit
      do_reset("t6");
      clear_log();
      send(8'h00); send(8'h01); send(8'h20); send(8'h08);
      do_reset("t6a");
      chk("t6 aborted no write", wa0.size(), 0);
      // Reset coincides with the 4th data byte: the write must be cancelled.
      send(8'h00); send(8'h01); send(8'h20); send(8'h08); send(8'h00);
      @(negedge clk);
      reset      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h05;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      chk("t6 cancel we", mem_we0, 0);
      chk("t6 cancel words", words_loaded0, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t6 cancel no write", wa0.size(), 0);
      frame1("t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
